// File: rtl/seq_reg_decoder.sv
// seq_reg_decoder: sequence register latch with extend/interrupt-force control and one-hot decodes.
// Define SEQ_REG_INDEX_EN to add the INDEX_VAL port and index the loaded word by it.
module seq_reg_decoder #(
    parameter int WORD_W   = 16,
    parameter int SQ_W     = 3,
    parameter int QC_W     = 2,
    parameter int RUPT_OPC = 0
) (
    input  logic                        SIM_CLK,
    input  logic                        SIM_RST,
    input  logic                        GOJAM,
    input  logic                        NISQ,
    input  logic                        T12,
    input  logic [WORD_W-1:0]           WL,
    input  logic                        EXTPLS,
    input  logic                        INHPLS,
    input  logic                        RELPLS,
    input  logic                        RESUME,
    input  logic                        RUPT_REQ,
`ifdef SEQ_REG_INDEX_EN
    input  logic [WORD_W-1:0]           INDEX_VAL,
`endif
    output logic [SQ_W-1:0]             SQ,
    output logic [QC_W-1:0]             QC,
    output logic                        SQR10,
    output logic                        SQEXT,
    output logic                        FUTEXT,
    output logic                        INHINT,
    output logic                        IIP,
    output logic                        RPTFRC,
    output logic                        LOADED,
    output logic [2**(SQ_W+1)-1:0]      OPDEC,
    output logic [2**QC_W-1:0]          QCDEC
);
    localparam int HDR_W = SQ_W + QC_W + 1;
    localparam int OD_W  = 2**(SQ_W+1);
    localparam int QD_W  = 2**QC_W;

    generate
        if (HDR_W > WORD_W) begin : g_bad_params
            $error("seq_reg_decoder: SQ_W+QC_W+1 must not exceed WORD_W");
        end
    endgenerate

    logic [WORD_W-1:0] w;
    logic [HDR_W-1:0]  hdr;
    logic              load;
    logic              frc;

`ifdef SEQ_REG_INDEX_EN
    assign w = WL + INDEX_VAL;
`else
    assign w = WL;
`endif
    // Only the top HDR_W bits of the word carry instruction fields.
    assign hdr  = HDR_W'(w >> (WORD_W - HDR_W));
    assign load = NISQ & T12;
    assign frc  = load & RUPT_REQ & ~INHINT & ~IIP & ~FUTEXT;

    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST || GOJAM) begin
            SQ     <= '0;
            QC     <= '0;
            SQR10  <= 1'b0;
            SQEXT  <= 1'b0;
            FUTEXT <= 1'b0;
            IIP    <= 1'b0;
            INHINT <= 1'b1;
            RPTFRC <= 1'b0;
            LOADED <= 1'b0;
        end else begin
            INHINT <= INHPLS | (INHINT & ~RELPLS);
            IIP    <= frc | (IIP & ~RESUME);
            RPTFRC <= frc;
            LOADED <= load;
            FUTEXT <= load ? EXTPLS : (FUTEXT | EXTPLS);
            if (frc) begin
                SQ    <= SQ_W'(RUPT_OPC);
                QC    <= '0;
                SQR10 <= 1'b0;
                SQEXT <= 1'b0;
            end else if (load) begin
                SQ    <= hdr[HDR_W-1 -: SQ_W];
                QC    <= hdr[QC_W:1];
                SQR10 <= hdr[0];
                SQEXT <= FUTEXT;
            end
        end
    end

    assign OPDEC = {{(OD_W-1){1'b0}}, 1'b1} << {SQEXT, SQ};
    assign QCDEC = {{(QD_W-1){1'b0}}, 1'b1} << QC;
endmodule

// File: tb/tb_seq_reg_decoder.sv
// tb_seq_reg_decoder: directed-vector bench for seq_reg_decoder with hand-computed expectations.
module tb_seq_reg_decoder;
    logic        SIM_CLK = 1'b0;
    logic        SIM_RST, GOJAM, NISQ, T12, EXTPLS, INHPLS, RELPLS, RESUME, RUPT_REQ;
    logic [15:0] WL;
`ifdef SEQ_REG_INDEX_EN
    logic [15:0] INDEX_VAL;
`endif
    logic [2:0]  SQ;
    logic [1:0]  QC;
    logic        SQR10, SQEXT, FUTEXT, INHINT, IIP, RPTFRC, LOADED;
    logic [15:0] OPDEC;
    logic [3:0]  QCDEC;
    int          n_vec = 0;
    int          n_err = 0;

    seq_reg_decoder dut (
        .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST), .GOJAM(GOJAM), .NISQ(NISQ), .T12(T12),
        .WL(WL), .EXTPLS(EXTPLS), .INHPLS(INHPLS), .RELPLS(RELPLS), .RESUME(RESUME),
        .RUPT_REQ(RUPT_REQ),
`ifdef SEQ_REG_INDEX_EN
        .INDEX_VAL(INDEX_VAL),
`endif
        .SQ(SQ), .QC(QC), .SQR10(SQR10), .SQEXT(SQEXT), .FUTEXT(FUTEXT), .INHINT(INHINT),
        .IIP(IIP), .RPTFRC(RPTFRC), .LOADED(LOADED), .OPDEC(OPDEC), .QCDEC(QCDEC)
    );

    always #5 SIM_CLK = ~SIM_CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge SIM_CLK);
        #1;
    endtask

    task automatic load(input logic [15:0] wl, input logic rupt);
        NISQ = 1'b1; T12 = 1'b1; WL = wl; RUPT_REQ = rupt;
        step();
        NISQ = 1'b0; T12 = 1'b0; RUPT_REQ = 1'b0;
    endtask

    initial begin
        SIM_RST = 1'b1; GOJAM = 1'b0; NISQ = 1'b0; T12 = 1'b0; WL = '0;
        EXTPLS = 1'b0; INHPLS = 1'b0; RELPLS = 1'b0; RESUME = 1'b0; RUPT_REQ = 1'b0;
`ifdef SEQ_REG_INDEX_EN
        INDEX_VAL = '0;
`endif
        step(); step();
        SIM_RST = 1'b0;
        chk("rst_sq", 32'(SQ), 0);         chk("rst_qc", 32'(QC), 0);
        chk("rst_sqr10", 32'(SQR10), 0);   chk("rst_sqext", 32'(SQEXT), 0);
        chk("rst_futext", 32'(FUTEXT), 0); chk("rst_iip", 32'(IIP), 0);
        chk("rst_inhint", 32'(INHINT), 1); chk("rst_rptfrc", 32'(RPTFRC), 0);
        chk("rst_loaded", 32'(LOADED), 0); chk("rst_opdec", 32'(OPDEC), 1);
        chk("rst_qcdec", 32'(QCDEC), 1);

        RELPLS = 1'b1; step(); RELPLS = 1'b0;
        chk("rel_inhint", 32'(INHINT), 0);

        NISQ = 1'b1; WL = 16'hA400; step(); NISQ = 1'b0;
        chk("nisq_only_loaded", 32'(LOADED), 0);
        chk("nisq_only_sq", 32'(SQ), 0);

        load(16'hA400, 1'b0);
        chk("a400_sq", 32'(SQ), 5);        chk("a400_qc", 32'(QC), 0);
        chk("a400_sqr10", 32'(SQR10), 1);  chk("a400_opdec", 32'(OPDEC), 32'h20);
        chk("a400_qcdec", 32'(QCDEC), 1);  chk("a400_loaded", 32'(LOADED), 1);
        step();
        chk("a400_loaded_drop", 32'(LOADED), 0);
        chk("a400_sq_hold", 32'(SQ), 5);

        load(16'h5800, 1'b0);
        chk("5800_sq", 32'(SQ), 2);        chk("5800_qc", 32'(QC), 3);
        chk("5800_sqr10", 32'(SQR10), 0);  chk("5800_qcdec", 32'(QCDEC), 8);

        EXTPLS = 1'b1; step(); EXTPLS = 1'b0;
        chk("ext_futext", 32'(FUTEXT), 1); chk("ext_sqext", 32'(SQEXT), 0);
        load(16'h2000, 1'b0);
        chk("ext_load_sqext", 32'(SQEXT), 1); chk("ext_load_sq", 32'(SQ), 1);
        chk("ext_load_opdec", 32'(OPDEC), 32'h200);
        chk("ext_load_futext", 32'(FUTEXT), 0);
        load(16'h2000, 1'b0);
        chk("plain_sqext", 32'(SQEXT), 0); chk("plain_opdec", 32'(OPDEC), 2);

        load(16'hFFFF, 1'b1);
        chk("frc_sq", 32'(SQ), 0);         chk("frc_qc", 32'(QC), 0);
        chk("frc_sqr10", 32'(SQR10), 0);   chk("frc_iip", 32'(IIP), 1);
        chk("frc_rptfrc", 32'(RPTFRC), 1); chk("frc_loaded", 32'(LOADED), 1);
        chk("frc_opdec", 32'(OPDEC), 1);
        RUPT_REQ = 1'b1; step(); RUPT_REQ = 1'b0;
        chk("frc_rptfrc_drop", 32'(RPTFRC), 0);
        load(16'hFFFF, 1'b1);
        chk("iip_block_sq", 32'(SQ), 7);   chk("iip_block_qc", 32'(QC), 3);
        chk("iip_block_sqr10", 32'(SQR10), 1);
        chk("iip_block_rptfrc", 32'(RPTFRC), 0);
        chk("iip_block_opdec", 32'(OPDEC), 32'h80);
        chk("iip_block_qcdec", 32'(QCDEC), 8);
        RESUME = 1'b1; step(); RESUME = 1'b0;
        chk("resume_iip", 32'(IIP), 0);

        EXTPLS = 1'b1; step(); EXTPLS = 1'b0;
        load(16'h4000, 1'b1);
        chk("fut_block_rptfrc", 32'(RPTFRC), 0);
        chk("fut_block_sq", 32'(SQ), 2);   chk("fut_block_sqext", 32'(SQEXT), 1);
        chk("fut_block_iip", 32'(IIP), 0);
        load(16'h0000, 1'b1);
        chk("refrc_rptfrc", 32'(RPTFRC), 1); chk("refrc_iip", 32'(IIP), 1);
        chk("refrc_sqext", 32'(SQEXT), 0);
        RESUME = 1'b1; step(); RESUME = 1'b0;

        INHPLS = 1'b1; RELPLS = 1'b1; step(); INHPLS = 1'b0; RELPLS = 1'b0;
        chk("inh_both", 32'(INHINT), 1);
        load(16'hA400, 1'b1);
        chk("inh_block_rptfrc", 32'(RPTFRC), 0);
        chk("inh_block_sq", 32'(SQ), 5);   chk("inh_block_iip", 32'(IIP), 0);

        EXTPLS = 1'b1; step(); EXTPLS = 1'b0;
        SIM_RST = 1'b1; RELPLS = 1'b1; EXTPLS = 1'b1;
        load(16'hFFFF, 1'b1);
        SIM_RST = 1'b0; RELPLS = 1'b0; EXTPLS = 1'b0;
        chk("rstld_sq", 32'(SQ), 0);         chk("rstld_qc", 32'(QC), 0);
        chk("rstld_sqr10", 32'(SQR10), 0);   chk("rstld_sqext", 32'(SQEXT), 0);
        chk("rstld_futext", 32'(FUTEXT), 0); chk("rstld_inhint", 32'(INHINT), 1);
        chk("rstld_loaded", 32'(LOADED), 0); chk("rstld_rptfrc", 32'(RPTFRC), 0);
        chk("rstld_iip", 32'(IIP), 0);

        load(16'hA400, 1'b0);
        chk("pre_gojam_sq", 32'(SQ), 5);
        GOJAM = 1'b1; step(); GOJAM = 1'b0;
        chk("gojam_sq", 32'(SQ), 0);         chk("gojam_sqr10", 32'(SQR10), 0);
        chk("gojam_loaded", 32'(LOADED), 0); chk("gojam_inhint", 32'(INHINT), 1);

`ifdef SEQ_REG_INDEX_EN
        INDEX_VAL = 16'h3000;
        load(16'h1000, 1'b0);
        chk("idx_sq", 32'(SQ), 2);
        INDEX_VAL = 16'h2000;
        load(16'hF000, 1'b0);
        chk("idx_wrap_sq", 32'(SQ), 0);      chk("idx_wrap_sqr10", 32'(SQR10), 0);
        INDEX_VAL = '0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/seq_reg_decoder.md
SEQ_REG_DECODER -- requirements
Module: seq_reg_decoder

Interface
REQ-001 Parameter WORD_W, default 16, sets the width of the write bus.
REQ-002 Parameter SQ_W, default 3, sets the width of the order-code field.
REQ-003 Parameter QC_W, default 2, sets the width of the quarter-code field.
REQ-004 Parameter RUPT_OPC, default 0, is the SQ_W-bit order code forced on interrupt entry.
REQ-005 SIM_CLK  in  1  is the single clock; all state SHALL update on its rising edge.
REQ-006 SIM_RST  in  1  is the reset, which SHALL be synchronous and active-high.
REQ-007 GOJAM  in  1  is a restart request, treated identically to SIM_RST.
REQ-008 NISQ  in  1  requests a new-instruction load at the next T12.
REQ-009 T12  in  1  is a one-cycle timing strobe.
REQ-010 WL  in  WORD_W  is the write bus that supplies the instruction word.
REQ-011 EXTPLS, INHPLS, RELPLS, RESUME, RUPT_REQ  in  1 each: extend pulse; inhibit set; inhibit release; interrupt exit; interrupt pending.
REQ-012 INDEX_VAL  in  WORD_W  is the index addend, present only with SEQ_REG_INDEX_EN.
REQ-013 SQ  out  SQ_W; QC  out  QC_W; SQR10  out  1: the latched instruction fields.
REQ-014 SQEXT, FUTEXT, INHINT, IIP  out  1 each: current-extended flag, future-extend flag, interrupt-inhibit flag, interrupt-in-progress flag.
REQ-015 RPTFRC  out  1 is the interrupt-force pulse; LOADED  out  1 is the load-complete pulse.
REQ-016 OPDEC  out  2^(SQ_W+1) is a one-hot decode of {SQEXT,SQ}; QCDEC  out  2^QC_W is a one-hot decode of QC.

Function
REQ-017 Load event = NISQ & T12 in the same cycle; NISQ without T12 SHALL have no effect.
REQ-018 On a load event, the block SHALL latch SQ = W[WORD_W-1 -: SQ_W], QC = the next QC_W bits below SQ, and SQR10 = the bit below QC, where W = WL.
REQ-019 On a load event, SQEXT SHALL take the pre-edge FUTEXT, and FUTEXT SHALL take EXTPLS.
REQ-020 Outside a load event, FUTEXT SHALL be FUTEXT | EXTPLS.
REQ-021 Force condition = load event & RUPT_REQ & ~INHINT & ~IIP & ~FUTEXT.
REQ-022 When the force condition holds, the block SHALL latch SQ=RUPT_OPC, QC=0, SQR10=0, SQEXT=0, set IIP, and pulse RPTFRC high for exactly one cycle; WL SHALL be ignored.
REQ-023 LOADED SHALL be high for the single cycle after every load event, forced or not.
REQ-024 Registered outputs SHALL update one cycle after the load event; OPDEC and QCDEC SHALL be combinational from the registers and always exactly one-hot.
REQ-025 INHPLS SHALL set INHINT and RELPLS SHALL clear it; when both are high in the same cycle, set SHALL win.
REQ-026 RESUME SHALL clear IIP; a cleared IIP SHALL first permit forcing at the following load.
REQ-027 RUPT_REQ is level-sensitive and SHALL NOT be latched; the block has no pending storage.
REQ-028 Parameter legality: SQ_W+QC_W+1 <= WORD_W; illegal values SHALL cause an elaboration-time error.

Reset
REQ-029 SIM_RST or GOJAM SHALL set SQ=0, QC=0, SQR10=0, SQEXT=0, FUTEXT=0, IIP=0, INHINT=1, RPTFRC=0, LOADED=0.
REQ-030 Reset SHALL have priority over every concurrent event, including a load in progress; a load coincident with reset SHALL be discarded.

Configuration
REQ-031 With SEQ_REG_INDEX_EN defined, W = (WL + INDEX_VAL) mod 2^WORD_W for non-forced loads.
REQ-032 Without SEQ_REG_INDEX_EN, the INDEX_VAL port SHALL be absent and W = WL.

Verification
REQ-033 Reset, then RELPLS; NISQ=T12=1 with WL=16'hA400 -> next cycle SQ=5, QC=0, SQR10=1, OPDEC bit5=1, LOADED=1 for one cycle.
REQ-034 EXTPLS pulse, then a load with WL=16'h2000 -> SQEXT=1, SQ=1, OPDEC bit9=1; the next plain load -> SQEXT=0.
REQ-035 INHINT=0, RUPT_REQ=1, load with WL=16'hFFFF -> SQ=RUPT_OPC=0, QC=0, IIP=1, RPTFRC high for 1 cycle; a second load with RUPT_REQ=1 -> no force.
REQ-036 INHPLS and RELPLS in the same cycle -> INHINT=1; with INHINT=1 and RUPT_REQ=1 -> no force; assert SIM_RST mid-load -> all fields 0, INHINT=1.
REQ-037 With SEQ_REG_INDEX_EN, WL=16'h1000 and INDEX_VAL=16'h3000 -> SQ=2; with WL=16'hF000 and INDEX_VAL=16'h2000 -> wraps to SQ=0.
